// File: rtl/bus_pkg.sv
// Shared types and constants for the paged bus decoder
// and its wait-state sequencer.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXT  = 2'd2
    } wait_st_e;

    localparam int RIW = 4;
    localparam logic [RIW-1:0] UNMAPPED = 4'hF;
    localparam logic [7:0] DEFAULT_DATA_DEF = 8'hFF;

endpackage

// File: rtl/bus_wait_fsm.sv
// Wait-state and slave-extension sequencer with timeout;
// reports ready, completion and forced completion.
module bus_wait_fsm
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mapped,
    input  logic [2:0] ws,
    input  logic       swait,
    output logic       rdy,
    output logic       done,
    output logic       tmo,
    output logic       idle
);

    localparam int TW = $clog2(TIMEOUT + 1);

    wait_st_e      state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    assign idle = (state_q == ST_IDLE);

    // Next state, counters and per-cycle completion flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        rdy     = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!mapped) begin
                    rdy  = 1'b1;
                    done = 1'b1;
                end else if (ws != 3'd0) begin
                    state_d = ST_WAIT;
                    cnt_d   = ws - 3'd1;
                end else if (swait) begin
                    state_d = ST_EXT;
                    tcnt_d  = TW'(1);
                end else begin
                    rdy  = 1'b1;
                    done = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (swait) begin
                    state_d = ST_EXT;
                    tcnt_d  = TW'(1);
                end else begin
                    state_d = ST_IDLE;
                    rdy     = 1'b1;
                    done    = 1'b1;
                end
            end
            ST_EXT: begin
                if (!swait) begin
                    state_d = ST_IDLE;
                    rdy     = 1'b1;
                    done    = 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    state_d = ST_IDLE;
                    rdy     = 1'b1;
                    done    = 1'b1;
                    tmo     = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset) begin
            rdy  = 1'b1;
            done = 1'b0;
            tmo  = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: rtl/bus_decode_ws.sv
// Page decoder with per-region wait states, registered
// read-data select and sticky error capture.
module bus_decode_ws
    import bus_pkg::*;
#(
    parameter int NREG = 6,
    parameter int DW = 8,
    parameter int AW = 16,
    parameter logic [63:0] PAGE_MAP =
        64'hFFFF_FFFF_FF54_3210,
    parameter logic [3*NREG-1:0] WS = '0,
    parameter int TIMEOUT = 16,
    parameter logic [DW-1:0] DEFAULT_DATA =
        DEFAULT_DATA_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      cpu_ab,
    input  logic               cpu_we,
    output logic [DW-1:0]      cpu_di,
    output logic               cpu_rdy,
    output logic [NREG-1:0]    cs,
    output logic [NREG-1:0]    we,
    input  logic [NREG*DW-1:0] slv_dout,
    input  logic [NREG-1:0]    slv_wait,
    input  logic               err_clr,
    output logic               bus_err,
    output logic [AW-1:0]      err_addr
);

    logic [3:0]     page;
    logic [RIW-1:0] ent, cur;
    logic [RIW-1:0] act_q, act_d;
    logic [RIW-1:0] sel_q, sel_d;
    logic           cur_map, cur_wait;
    logic [2:0]     cur_ws;
    logic           rdy, done, tmo, idle;
    logic           err_ev;
    logic           bus_err_q, bus_err_d;
    logic [AW-1:0]  err_addr_q, err_addr_d;

    // Address decode; region is frozen while stalled.
    always_comb begin
        page     = cpu_ab[AW-1 -: 4];
        ent      = PAGE_MAP[{page, 2'b00} +: 4];
        cur      = idle ? ent : act_q;
        cs       = '0;
        cur_map  = 1'b0;
        cur_ws   = 3'd0;
        cur_wait = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (ent == RIW'(r))
                cs[r] = ~reset;
            if (cur == RIW'(r)) begin
                cur_map  = 1'b1;
                cur_ws   = WS[3*r +: 3];
                cur_wait = slv_wait[r];
            end
        end
    end

    bus_wait_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .mapped(cur_map),
        .ws    (cur_ws),
        .swait (cur_wait),
        .rdy   (rdy),
        .done  (done),
        .tmo   (tmo),
        .idle  (idle)
    );

    // Write strobe, select capture and error update.
    always_comb begin
        we = '0;
        for (int r = 0; r < NREG; r++)
            if (cur == RIW'(r))
                we[r] = done & cpu_we & ~tmo;
        act_d = idle ? ent : act_q;
        sel_d = sel_q;
        if (done)
            sel_d = (cur_map && !tmo) ? cur : UNMAPPED;
        err_ev = done & (~cur_map | tmo);
        bus_err_d = err_ev | (bus_err_q & ~err_clr);
        err_addr_d = err_addr_q;
        if (err_ev && (!bus_err_q || err_clr))
            err_addr_d = cpu_ab;
    end

    // Read data from the region of the last completion.
    always_comb begin
        cpu_di = DEFAULT_DATA;
        for (int r = 0; r < NREG; r++)
            if (!reset && sel_q == RIW'(r))
                cpu_di = slv_dout[r*DW +: DW];
    end

    // Select, active region and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q      <= UNMAPPED;
            sel_q      <= UNMAPPED;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            act_q      <= act_d;
            sel_q      <= sel_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign cpu_rdy  = rdy;
    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_decode_ws.sv
// Directed bench for bus_decode_ws: vector table plus
// multi-cycle wait, extension, timeout and reset cases.
module tb_bus_decode_ws;

    localparam logic [17:0] WSV =
        {3'd0, 3'd2, 3'd0, 3'd3, 3'd1, 3'd0};

    logic        clk;
    logic        reset;
    logic [15:0] cpu_ab;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic [5:0]  cs;
    logic [5:0]  we;
    logic [47:0] slv_dout;
    logic [5:0]  slv_wait;
    logic        err_clr;
    logic        bus_err;
    logic [15:0] err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    bus_decode_ws #(
        .NREG(6), .DW(8), .AW(16),
        .PAGE_MAP(64'hFFFF_FFFF_FF54_3210),
        .WS(WSV), .TIMEOUT(16),
        .DEFAULT_DATA(8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cpu_ab  (cpu_ab),
        .cpu_we  (cpu_we),
        .cpu_di  (cpu_di),
        .cpu_rdy (cpu_rdy),
        .cs      (cs),
        .we      (we),
        .slv_dout(slv_dout),
        .slv_wait(slv_wait),
        .err_clr (err_clr),
        .bus_err (bus_err),
        .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ab;
        logic        wr;
        logic        clr;
        logic [5:0]  cs;
        logic [5:0]  we;
        logic        rdy;
        logic [7:0]  di;
        logic        err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, wp, wc, c;
        logic fin;
        vecs[0] = '{16'h0010, 1'b0, 1'b0, 6'h01,
                    6'h00, 1'b1, 8'hFF, 1'b0};
        vecs[1] = '{16'h3000, 1'b0, 1'b0, 6'h08,
                    6'h00, 1'b1, 8'hA5, 1'b0};
        vecs[2] = '{16'h5004, 1'b1, 1'b0, 6'h20,
                    6'h20, 1'b1, 8'h33, 1'b0};
        vecs[3] = '{16'h0000, 1'b1, 1'b0, 6'h01,
                    6'h01, 1'b1, 8'h55, 1'b0};
        vecs[4] = '{16'h3FFF, 1'b0, 1'b0, 6'h08,
                    6'h00, 1'b1, 8'hA5, 1'b0};
        vecs[5] = '{16'hF000, 1'b0, 1'b0, 6'h00,
                    6'h00, 1'b1, 8'h33, 1'b0};
        vecs[6] = '{16'h5000, 1'b0, 1'b0, 6'h20,
                    6'h00, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{16'h0001, 1'b0, 1'b1, 6'h01,
                    6'h00, 1'b1, 8'h55, 1'b1};
        vecs[8] = '{16'h6000, 1'b1, 1'b0, 6'h00,
                    6'h00, 1'b1, 8'hA5, 1'b0};
        vecs[9] = '{16'h0000, 1'b0, 1'b0, 6'h01,
                    6'h00, 1'b1, 8'hFF, 1'b1};

        slv_dout = {8'h55, 8'h44, 8'h33,
                    8'h22, 8'h11, 8'hA5};
        slv_wait = '0;
        err_clr  = 1'b0;
        reset    = 1'b1;
        cpu_ab   = 16'h2000;
        cpu_we   = 1'b1;

        // reset state
        next();
        #2;
        chk("rst rdy", 32'(cpu_rdy), 32'd1);
        chk("rst cs", 32'(cs), 32'd0);
        chk("rst we", 32'(we), 32'd0);
        chk("rst di", 32'(cpu_di), 32'hFF);
        chk("rst err", 32'(bus_err), 32'd0);
        chk("rst eaddr", 32'(err_addr), 32'd0);
        next();
        reset = 1'b0;

        // single-cycle vector table
        for (int i = 0; i < 10; i++) begin
            cpu_ab  = vecs[i].ab;
            cpu_we  = vecs[i].wr;
            err_clr = vecs[i].clr;
            #2;
            chk($sformatf("v%0d cs", i),
                32'(cs), 32'(vecs[i].cs));
            chk($sformatf("v%0d we", i),
                32'(we), 32'(vecs[i].we));
            chk($sformatf("v%0d rdy", i),
                32'(cpu_rdy), 32'(vecs[i].rdy));
            chk($sformatf("v%0d di", i),
                32'(cpu_di), 32'(vecs[i].di));
            chk($sformatf("v%0d err", i),
                32'(bus_err), 32'(vecs[i].err));
            next();
        end
        err_clr = 1'b0;
        chk("tbl eaddr", 32'(err_addr), 32'h6000);

        // three wait states, one write strobe
        cpu_ab = 16'h2001;
        cpu_we = 1'b1;
        lo = 0; wp = 0; wc = -1; fin = 1'b0;
        for (c = 0; c < 12 && !fin; c++) begin
            #2;
            if (!cpu_rdy) lo++;
            if (we != 6'h00) begin
                wp++;
                if (we == 6'h04) wc = c;
            end
            if (cpu_rdy) fin = 1'b1;
            else next();
        end
        chk("ws3 done", 32'(fin), 32'd1);
        chk("ws3 low", 32'(lo), 32'd3);
        chk("ws3 pulses", 32'(wp), 32'd1);
        chk("ws3 pulse cyc", 32'(wc), 32'd3);
        next();

        // one wait state extended by slv_wait
        cpu_ab = 16'h1000;
        cpu_we = 1'b0;
        lo = 0; fin = 1'b0;
        for (c = 0; c < 20 && !fin; c++) begin
            slv_wait = (c >= 1 && c <= 5) ?
                       6'h02 : 6'h00;
            #2;
            if (!cpu_rdy) lo++;
            if (cpu_rdy) fin = 1'b1;
            else next();
        end
        chk("ext done", 32'(fin), 32'd1);
        chk("ext low", 32'(lo), 32'd6);
        next();
        slv_wait = '0;
        cpu_ab = 16'h0000;
        #2;
        chk("ext di", 32'(cpu_di), 32'h11);

        // unmapped reads and error capture
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        #2;
        chk("clr0 err", 32'(bus_err), 32'd0);
        cpu_ab = 16'h9000;
        #1;
        chk("um rdy", 32'(cpu_rdy), 32'd1);
        chk("um cs", 32'(cs), 32'd0);
        next();
        cpu_ab = 16'hA000;
        #2;
        chk("um di", 32'(cpu_di), 32'hFF);
        chk("um err", 32'(bus_err), 32'd1);
        next();
        #2;
        chk("um eaddr", 32'(err_addr), 32'h9000);
        chk("um di2", 32'(cpu_di), 32'hFF);
        cpu_ab  = 16'hB000;
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        #2;
        chk("clr+err err", 32'(bus_err), 32'd1);
        chk("clr+err eaddr", 32'(err_addr),
            32'hB000);
        cpu_ab  = 16'h0000;
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        #2;
        chk("clr err", 32'(bus_err), 32'd0);
        chk("clr di", 32'(cpu_di), 32'hA5);

        // stuck slv_wait on a write forces timeout
        cpu_ab   = 16'h3000;
        cpu_we   = 1'b1;
        slv_wait = 6'h08;
        lo = 0; wp = 0; fin = 1'b0;
        for (c = 0; c < 40 && !fin; c++) begin
            #2;
            if (!cpu_rdy) lo++;
            if (we != 6'h00) wp++;
            if (cpu_rdy) fin = 1'b1;
            else next();
        end
        chk("tmo done", 32'(fin), 32'd1);
        chk("tmo low", 32'(lo), 32'd16);
        chk("tmo we", 32'(wp), 32'd0);
        next();
        slv_wait = '0;
        cpu_ab   = 16'h0000;
        cpu_we   = 1'b0;
        err_clr  = 1'b1;
        #2;
        chk("tmo err", 32'(bus_err), 32'd1);
        chk("tmo eaddr", 32'(err_addr), 32'h3000);
        chk("tmo di", 32'(cpu_di), 32'hFF);
        next();
        err_clr = 1'b0;
        #2;
        chk("tmo clr", 32'(bus_err), 32'd0);

        // reset in the second wait cycle of a write
        cpu_ab = 16'h2000;
        cpu_we = 1'b1;
        #1;
        chk("mr c0 rdy", 32'(cpu_rdy), 32'd0);
        chk("mr c0 di", 32'(cpu_di), 32'hA5);
        next();
        reset = 1'b1;
        #2;
        chk("mr rdy", 32'(cpu_rdy), 32'd1);
        chk("mr we", 32'(we), 32'd0);
        chk("mr cs", 32'(cs), 32'd0);
        chk("mr di", 32'(cpu_di), 32'hFF);
        next();
        reset  = 1'b0;
        cpu_ab = 16'h0000;
        cpu_we = 1'b0;
        #2;
        chk("pr rdy", 32'(cpu_rdy), 32'd1);
        chk("pr cs", 32'(cs), 32'h01);
        chk("pr we", 32'(we), 32'd0);
        chk("pr di", 32'(cpu_di), 32'hFF);
        chk("pr err", 32'(bus_err), 32'd0);
        next();
        #2;
        chk("pr di2", 32'(cpu_di), 32'hA5);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_decode_ws.md
BUS_DECODE_WS -- requirements
Module: bus_decode_ws

Interface
REQ-001 Parameter: NREG, 6, number of slave regions (1..8).
REQ-002 Parameter: DW, 8, data width.
REQ-003 Parameter: AW, 16, CPU address width; region select uses cpu_ab[AW-1:AW-4] (16 pages).
REQ-004 Parameter: PAGE_MAP, 64-bit vector, 4 bits per page (page 0 in LSBs); value = region index, 4'hF = unmapped.
REQ-005 Parameter: WS, 3*NREG-bit vector, fixed wait states per region (0..7).
REQ-006 Parameter: TIMEOUT, 16, max cycles slv_wait is honoured per access.
REQ-007 Parameter: DEFAULT_DATA, 8'hFF, read data for unmapped pages.
REQ-008 clk  in  1  single system clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 cpu_ab  in  AW  CPU address bus.
REQ-011 cpu_we  in  1  CPU write enable.
REQ-012 cpu_di  out  DW  read data to CPU.
REQ-013 cpu_rdy  out  1  CPU ready; low stalls CPU, which holds cpu_ab/cpu_we/cpu_do.
REQ-014 cs  out  NREG  one-hot chip select, combinational from cpu_ab.
REQ-015 we  out  NREG  one-hot write strobe, one cycle per write access.
REQ-016 slv_dout  in  NREG*DW  flattened slave read data, region r at [r*DW +: DW].
REQ-017 slv_wait  in  NREG  per-slave extension request.
REQ-018 err_clr  in  1  clears bus_err.
REQ-019 bus_err  out  1  sticky error flag.
REQ-020 err_addr  out  AW  address of first error since last clear.

Function
REQ-021 Region r = PAGE_MAP[4*page +: 4]; cs[r] SHALL be high for every cycle cpu_ab maps to r; no cs bit for unmapped pages.
REQ-022 Access starting cycle N with WS[r]=k: cpu_rdy low in cycles N..N+k-1, high in N+k (completion cycle), absent slv_wait.
REQ-023 If slv_wait[r] is high in the would-be completion cycle, cpu_rdy stays low and completion moves to the first cycle slv_wait[r] is low.
REQ-024 FSM states IDLE, WAIT, EXT; IDLE->WAIT on new access with k>0; WAIT->EXT when count expires and slv_wait high; WAIT/EXT->IDLE on completion.
REQ-025 we[r] SHALL pulse high only in the completion cycle of a write; exactly one pulse per write regardless of stalls.
REQ-026 Read data: selected region index registered on completion cycle; cpu_di = slv_dout of that region in the following cycle (1-cycle latency), held until next completion.
REQ-027 Unmapped access: completes with k=0; cpu_di = DEFAULT_DATA; writes discarded; bus_err set.
REQ-028 Timeout: if slv_wait held TIMEOUT cycles, access SHALL be forced complete, cpu_di = DEFAULT_DATA for a read, we pulse suppressed, bus_err set.
REQ-029 err_addr captured only when bus_err transitions 0->1; later errors do not overwrite.
REQ-030 err_clr and new error in same cycle: error wins (bus_err stays 1, err_addr = new address).
REQ-031 Back-to-back accesses: completion cycle of access N and start of access N+1 are distinct cycles; cpu_ab change while cpu_rdy low is illegal and ignored.

Reset
REQ-032 While reset high: cpu_rdy=1, cs=0, we=0, FSM=IDLE, counters=0, bus_err=0, err_addr=0, registered select = unmapped (cpu_di=DEFAULT_DATA).
REQ-033 Reset mid-wait aborts the access with no we pulse; first cycle after reset starts a fresh access.

Structure
REQ-034 Shared package bus_pkg: FSM state enum, UNMAPPED=4'hF, region-index width, DEFAULT_DATA default.
REQ-035 Wait/timeout counting in one sub-module bus_wait_fsm; decode and data mux in bus_decode_ws.

Verification
REQ-036 WS=0, read page 0 region 0, slv_dout=8'hA5 -> cpu_rdy never low, cpu_di=8'hA5 one cycle after access.
REQ-037 WS[2]=3, write 8'h3C to 0x2001 -> cpu_rdy low 3 cycles, single we[2] pulse in 4th cycle.
REQ-038 WS=1, slv_wait held 5 cycles -> cpu_rdy low 6 cycles total, one completion.
REQ-039 Read unmapped 0x9000 then 0xA000 -> cpu_di=8'hFF, bus_err=1, err_addr=0x9000; err_clr -> bus_err=0.
REQ-040 slv_wait stuck high, TIMEOUT=16 -> forced completion after 16 cycles, no we, bus_err=1.
REQ-041 reset asserted in 2nd wait cycle -> cpu_rdy=1 next cycle, no we pulse, cpu_di=8'hFF.
